// File: rtl/unet_io_pkg.sv
// Shared constants and types for the UNET output packing path.
package unet_io_pkg;

   localparam int unsigned DEF_DATA_W    = 12;
   localparam int unsigned DEF_LANE_W    = 16;
   localparam int unsigned DEF_FRAME_LEN = 4096;

   // Keeps the pixel counter at least one bit wide for single-pixel frames.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int unsigned IDX_W = idx_width(DEF_FRAME_LEN);

   typedef enum logic {
      StLow  = 1'b0,
      StHigh = 1'b1
   } pack_state_e;

   // Beat record: {tlast, tkeep, tdata}.
   function automatic int unsigned beat_width(input int unsigned lane_w);
      return 2 * lane_w + (2 * lane_w) / 8 + 1;
   endfunction

endpackage

// File: rtl/unet_skid_fifo2.sv
// Two-entry register FIFO; entry 0 is the head and drives dout directly.
module unet_skid_fifo2 #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic [1:0]       cnt
);

   logic [WIDTH-1:0] e0_q, e0_d;
   logic [WIDTH-1:0] e1_q, e1_d;
   logic [1:0]       cnt_q, cnt_d;

   always_comb begin
      e0_d  = e0_q;
      e1_d  = e1_q;
      cnt_d = cnt_q;
      unique case ({push, pop})
         2'b10: begin
            if (cnt_q == 2'd0) e0_d = din;
            else               e1_d = din;
            cnt_d = cnt_q + 2'd1;
         end
         2'b01: begin
            e0_d  = e1_q;
            e1_d  = '0;
            cnt_d = cnt_q - 2'd1;
         end
         2'b11: begin
            if (cnt_q == 2'd1) begin
               e0_d = din;
            end else begin
               e0_d = e1_q;
               e1_d = din;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         e0_q  <= '0;
         e1_q  <= '0;
         cnt_q <= 2'd0;
      end else begin
         e0_q  <= e0_d;
         e1_q  <= e1_d;
         cnt_q <= cnt_d;
      end
   end

   assign dout = e0_q;
   assign cnt  = cnt_q;

endmodule

// File: rtl/unet_out_packer.sv
// Packs two zero-extended pixels per AXI4-Stream beat; odd frames end on a half-keep beat.
module unet_out_packer
   import unet_io_pkg::*;
#(
   parameter int unsigned DATA_W    = DEF_DATA_W,
   parameter int unsigned LANE_W    = DEF_LANE_W,
   parameter int unsigned FRAME_LEN = DEF_FRAME_LEN
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_W-1:0]     in_dat,
   input  logic                  in_vld,
   output logic                  in_rdy,
   output logic [2*LANE_W-1:0]   m_tdata,
   output logic [2*LANE_W/8-1:0] m_tkeep,
   output logic                  m_tlast,
   output logic                  m_tvalid,
   input  logic                  m_tready,
   output logic                  frame_done
);

   localparam int unsigned KEEP_W = 2 * LANE_W / 8;
   localparam int unsigned BEAT_W = beat_width(LANE_W);
   localparam int unsigned IW     = idx_width(FRAME_LEN);
   localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_LEN - 1);

   pack_state_e       state_q;
   logic [DATA_W-1:0] lane0_q;
   logic [IW-1:0]     pix_idx_q;
   logic              rdy_en_q;
   logic              frame_done_q;

   logic              at_last, push_on_accept, accept, push, pop;
   logic [1:0]        fifo_cnt;
   logic [LANE_W-1:0] lane_lo, lane_hi;
   logic [KEEP_W-1:0] keep;
   logic              last;
   logic [BEAT_W-1:0] beat_in, beat_out;

   assign at_last        = (pix_idx_q == LAST_IDX);
   assign push_on_accept = (state_q == StHigh) | at_last;
   // rdy_en_q holds in_rdy low through reset and releases it one edge later.
   assign in_rdy         = rdy_en_q & (!push_on_accept | (fifo_cnt != 2'd2));
   assign accept         = in_vld & in_rdy;
   assign push           = accept & push_on_accept;
   assign pop            = m_tvalid & m_tready;

   always_comb begin
      lane_lo = '0;
      lane_hi = '0;
      keep    = '0;
      last    = 1'b0;
      if (state_q == StHigh) begin
         lane_lo[DATA_W-1:0] = lane0_q;
         lane_hi[DATA_W-1:0] = in_dat;
         keep                = '1;
         last                = at_last;
      end else begin
         lane_lo[DATA_W-1:0]   = in_dat;
         keep[KEEP_W/2-1:0]    = '1;
         last                  = 1'b1;
      end
   end

   assign beat_in = {last, keep, lane_hi, lane_lo};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= StLow;
         lane0_q      <= '0;
         pix_idx_q    <= '0;
         rdy_en_q     <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         rdy_en_q     <= 1'b1;
         frame_done_q <= pop & m_tlast;
         if (accept) begin
            pix_idx_q <= at_last ? '0 : pix_idx_q + IW'(1);
            if (state_q == StHigh) begin
               state_q <= StLow;
            end else if (!at_last) begin
               state_q <= StHigh;
               lane0_q <= in_dat;
            end
         end
      end
   end

   unet_skid_fifo2 #(
      .WIDTH (BEAT_W)
   ) u_fifo (
      .clk  (clk),
      .rst  (rst),
      .push (push),
      .pop  (pop),
      .din  (beat_in),
      .dout (beat_out),
      .cnt  (fifo_cnt)
   );

   assign m_tdata    = beat_out[2*LANE_W-1:0];
   assign m_tkeep    = beat_out[2*LANE_W +: KEEP_W];
   assign m_tlast    = beat_out[BEAT_W-1];
   assign m_tvalid   = (fifo_cnt != 2'd0);
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_unet_out_packer.sv
// Bench for unet_out_packer: two instances (FRAME_LEN 4 and 3) against a queue-based model.
module tb_unet_out_packer;

   logic        clk = 1'b0;
   logic        rst;
   logic [11:0] in_dat[2];
   logic        in_vld[2];
   logic        in_rdy[2];
   logic [31:0] m_tdata[2];
   logic [3:0]  m_tkeep[2];
   logic        m_tlast[2];
   logic        m_tvalid[2];
   logic        m_tready[2];
   logic        frame_done[2];

   always #5 clk = ~clk;

   unet_out_packer #(.DATA_W(12), .LANE_W(16), .FRAME_LEN(4)) u_dut4 (
      .clk(clk), .rst(rst), .in_dat(in_dat[0]), .in_vld(in_vld[0]), .in_rdy(in_rdy[0]),
      .m_tdata(m_tdata[0]), .m_tkeep(m_tkeep[0]), .m_tlast(m_tlast[0]),
      .m_tvalid(m_tvalid[0]), .m_tready(m_tready[0]), .frame_done(frame_done[0])
   );

   unet_out_packer #(.DATA_W(12), .LANE_W(16), .FRAME_LEN(3)) u_dut3 (
      .clk(clk), .rst(rst), .in_dat(in_dat[1]), .in_vld(in_vld[1]), .in_rdy(in_rdy[1]),
      .m_tdata(m_tdata[1]), .m_tkeep(m_tkeep[1]), .m_tlast(m_tlast[1]),
      .m_tvalid(m_tvalid[1]), .m_tready(m_tready[1]), .frame_done(frame_done[1])
   );

   int n_cmp = 0;
   int n_err = 0;

   // Model: pixel position, held pixel, and the list of beats produced but not yet taken.
   int          idx[2];
   bit          held_v[2];
   logic [11:0] held[2];
   logic [31:0] pd[2][4];
   logic [3:0]  pk[2][4];
   logic        pl[2][4];
   int          pn[2];
   bit          done_e[2];
   bit          en[2];
   int          done_cnt[2];

   logic [31:0] log_d[2][1024];
   logic [3:0]  log_k[2][1024];
   logic        log_l[2][1024];
   int          log_n[2];

   function automatic int fl(input int k);
      return (k == 0) ? 4 : 3;
   endfunction

   task automatic chk(input string nm, input int k, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s[%0d]: got %h want %h at %0t", nm, k, act, exp, $time);
      end
   endtask

   function automatic void push_beat(input int k, input logic [31:0] d, input logic [3:0] kp,
                                     input logic l);
      if (pn[k] < 4) begin
         pd[k][pn[k]] = d;
         pk[k][pn[k]] = kp;
         pl[k][pn[k]] = l;
         pn[k]++;
      end
   endfunction

   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         bit er, pop;
         if (!rst) begin
            chk("rst_in_rdy", k, in_rdy[k], 0);
            chk("rst_tvalid", k, m_tvalid[k], 0);
            chk("rst_tdata", k, m_tdata[k], 0);
            chk("rst_tkeep", k, m_tkeep[k], 0);
            chk("rst_tlast", k, m_tlast[k], 0);
            chk("rst_frame_done", k, frame_done[k], 0);
            idx[k] = 0; held_v[k] = 0; pn[k] = 0; done_e[k] = 0; en[k] = 0;
         end else begin
            er = en[k] && (!(held_v[k] || idx[k] == fl(k) - 1) || pn[k] < 2);
            chk("in_rdy", k, in_rdy[k], er);
            chk("tvalid", k, m_tvalid[k], pn[k] != 0);
            if (pn[k] != 0) begin
               chk("tdata", k, m_tdata[k], pd[k][0]);
               chk("tkeep", k, m_tkeep[k], pk[k][0]);
               chk("tlast", k, m_tlast[k], pl[k][0]);
            end
            chk("frame_done", k, frame_done[k], done_e[k]);
            if (frame_done[k]) done_cnt[k]++;
            if (m_tvalid[k] && m_tready[k] && log_n[k] < 1024) begin
               log_d[k][log_n[k]] = m_tdata[k];
               log_k[k][log_n[k]] = m_tkeep[k];
               log_l[k][log_n[k]] = m_tlast[k];
               log_n[k]++;
            end
            pop = (pn[k] != 0) && m_tready[k];
            done_e[k] = pop && pl[k][0];
            if (pop) begin
               for (int j = 0; j < 3; j++) begin
                  pd[k][j] = pd[k][j+1]; pk[k][j] = pk[k][j+1]; pl[k][j] = pl[k][j+1];
               end
               pn[k]--;
            end
            if (in_vld[k] && er) begin
               if (held_v[k]) begin
                  push_beat(k, {4'h0, in_dat[k], 4'h0, held[k]}, 4'hF, idx[k] == fl(k) - 1);
                  held_v[k] = 0;
               end else if (idx[k] == fl(k) - 1) begin
                  push_beat(k, {20'h0, in_dat[k]}, 4'h3, 1'b1);
               end else begin
                  held[k] = in_dat[k];
                  held_v[k] = 1;
               end
               idx[k] = (idx[k] == fl(k) - 1) ? 0 : idx[k] + 1;
            end
            en[k] = 1;
         end
      end
   end

   task automatic send_pix(input int k, input logic [11:0] p);
      bit a;
      int g;
      in_vld[k] = 1'b1;
      in_dat[k] = p;
      g = 0;
      do begin
         @(negedge clk);
         a = in_rdy[k];
         @(posedge clk);
         #1;
         g++;
      end while (!a && g < 200);
      if (!a) begin
         n_cmp++;
         n_err++;
         $display("FAIL send_timeout[%0d]: got no accept want accept", k);
      end
      in_vld[k] = 1'b0;
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int  acc, base;
      bit  a, d0, d1;
      for (int k = 0; k < 2; k++) begin
         in_vld[k] = 1'b1; in_dat[k] = 12'h5A5; m_tready[k] = 1'b1;
         log_n[k] = 0; done_cnt[k] = 0;
      end
      rst = 1'b0;
      cycles(3);
      in_vld[0] = 1'b0; in_vld[1] = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      chk("rdy_at_release", 0, in_rdy[0], 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("rdy_after_release", 0, in_rdy[0], 1);
      @(posedge clk); #1;

      // Even frame, free-flowing sink.
      send_pix(0, 12'h001); send_pix(0, 12'h002); send_pix(0, 12'h003); send_pix(0, 12'h004);
      cycles(4);
      chk("t2_nbeats", 0, log_n[0], 2);
      chk("t2_b0", 0, log_d[0][0], 32'h0002_0001);
      chk("t2_k0", 0, log_k[0][0], 4'hF);
      chk("t2_l0", 0, log_l[0][0], 0);
      chk("t2_b1", 0, log_d[0][1], 32'h0004_0003);
      chk("t2_l1", 0, log_l[0][1], 1);
      chk("t2_done", 0, done_cnt[0], 1);

      // Odd frame.
      send_pix(1, 12'hABC); send_pix(1, 12'h123); send_pix(1, 12'hFFF);
      cycles(4);
      chk("t3_b0", 1, log_d[1][0], 32'h0123_0ABC);
      chk("t3_l0", 1, log_l[1][0], 0);
      chk("t3_b1", 1, log_d[1][1], 32'h0000_0FFF);
      chk("t3_k1", 1, log_k[1][1], 4'h3);
      chk("t3_l1", 1, log_l[1][1], 1);

      // Backpressure: fifth pixel fits in lane0, sixth must stall.
      m_tready[0] = 1'b0;
      acc = 0;
      in_vld[0] = 1'b1;
      in_dat[0] = 12'h101;
      repeat (10) begin
         @(negedge clk);
         a = in_rdy[0];
         @(posedge clk); #1;
         if (a && in_vld[0]) begin
            acc++;
            in_dat[0] = 12'(12'h101 + acc);
            if (acc == 6) in_vld[0] = 1'b0;
         end
      end
      chk("t4_accepted", 0, acc, 5);
      chk("t4_no_drain", 0, log_n[0], 2);
      m_tready[0] = 1'b1;
      send_pix(0, 12'h106);
      cycles(6);
      chk("t4_nbeats", 0, log_n[0], 5);
      chk("t4_b0", 0, log_d[0][2], 32'h0102_0101);
      chk("t4_b1", 0, log_d[0][3], 32'h0104_0103);
      chk("t4_l1", 0, log_l[0][3], 1);
      chk("t4_b2", 0, log_d[0][4], 32'h0106_0105);
      chk("t4_l2", 0, log_l[0][4], 0);

      // Odd frames wrapping back-to-back.
      base = log_n[1];
      for (int i = 0; i < 9; i++) send_pix(1, 12'($urandom));
      cycles(6);
      chk("t5_nbeats", 1, log_n[1] - base, 6);
      for (int j = 0; j < 6; j++) begin
         chk("t5_last", 1, log_l[1][base+j], (j % 2) == 1);
         chk("t5_keep", 1, log_k[1][base+j], ((j % 2) == 1) ? 4'h3 : 4'hF);
      end

      // Reset with one pixel held and one beat queued.
      m_tready[0] = 1'b0;
      send_pix(0, 12'h201); send_pix(0, 12'h202); send_pix(0, 12'h203);
      cycles(2);
      rst = 1'b0;
      cycles(2);
      rst = 1'b1;
      m_tready[0] = 1'b1;
      cycles(1);
      base = log_n[0];
      send_pix(0, 12'h301); send_pix(0, 12'h302); send_pix(0, 12'h303); send_pix(0, 12'h304);
      cycles(5);
      chk("t6_nbeats", 0, log_n[0] - base, 2);
      chk("t6_b0", 0, log_d[0][base], 32'h0302_0301);
      chk("t6_l0", 0, log_l[0][base], 0);
      chk("t6_b1", 0, log_d[0][base+1], 32'h0304_0303);
      chk("t6_l1", 0, log_l[0][base+1], 1);

      // Random traffic with random sink stalls on both instances.
      d0 = 0; d1 = 0;
      fork
         begin
            for (int i = 0; i < 300; i++) begin
               if ($urandom_range(0, 3) == 0) cycles(1);
               send_pix(0, 12'($urandom));
            end
            d0 = 1;
         end
         begin
            for (int i = 0; i < 300; i++) begin
               if ($urandom_range(0, 3) == 0) cycles(1);
               send_pix(1, 12'($urandom));
            end
            d1 = 1;
         end
         begin
            for (int c = 0; c < 20000 && !(d0 && d1); c++) begin
               @(posedge clk); #1;
               m_tready[0] = ($urandom_range(0, 2) != 0);
               m_tready[1] = ($urandom_range(0, 1) == 1);
            end
         end
      join
      m_tready[0] = 1'b1; m_tready[1] = 1'b1;
      cycles(8);
      chk("drained", 0, m_tvalid[0], 0);
      chk("drained", 1, m_tvalid[1], 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
